text_write_ctrl: RTL and testbench
==================================

TEXT_WRITE_CTRL -- requirements
Module: text_write_ctrl

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 60, text rows per screen.
REQ-003 Parameter ADDR_W, default 13, tile memory address width; COLS*ROWS SHALL fit in ADDR_W bits.
REQ-004 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 char_valid  in  1  character stream valid.
REQ-007 char_data  in  8  character code.
REQ-008 char_ready  out  1  block can accept a character this cycle.
REQ-009 clr_req  in  1  request a full-screen clear.
REQ-010 clr_busy  out  1  clear sweep in progress.
REQ-011 wr_en  out  1  tile memory write strobe, registered.
REQ-012 wr_addr  out  ADDR_W  tile memory write address, registered.
REQ-013 wr_data  out  8  tile memory write data, registered.
REQ-014 cursor_x  out  7  current column; cursor_y  out  6  current row.

Function
REQ-015 FSM states IDLE and CLEAR; the block SHALL have no other states.
REQ-016 char_ready SHALL be combinational: 1 only when state==IDLE and clr_req==0.
REQ-017 A character SHALL transfer on a rising edge where char_valid and char_ready are both 1; up to one transfer per cycle, no bubbles.
REQ-018 Printable codes (anything except 0x08, 0x0A, 0x0D) SHALL produce wr_en=1, wr_addr=cursor_y*COLS+cursor_x, wr_data=char_data on the cycle after the transfer.
REQ-019 After a printable code: cursor_x+1; if cursor_x was COLS-1, cursor_x->0 and cursor_y+1.
REQ-020 0x0A (LF): no write; cursor_x->0, cursor_y+1.
REQ-021 0x0D (CR): no write; cursor_x->0, cursor_y unchanged.
REQ-022 0x08 (BS): no write; cursor_x-1 if cursor_x>0, else unchanged; cursor_y unchanged.
REQ-023 A cursor_y increment from ROWS-1 SHALL wrap cursor_y to 0; no scrolling.
REQ-024 wr_en SHALL be 0 in every cycle without a write; wr_addr and wr_data SHALL hold their last values when wr_en is 0.
REQ-025 clr_req=1 in IDLE SHALL enter CLEAR on the next edge; a simultaneous char_valid SHALL NOT be accepted.
REQ-026 In CLEAR, the block SHALL write 0x20 to addresses 0 through COLS*ROWS-1 in ascending order, one per cycle, wr_en continuously 1.
REQ-027 The first clear write SHALL appear the cycle after CLEAR entry; the last write (COLS*ROWS-1) SHALL be followed by a return to IDLE with cursor_x=cursor_y=0.
REQ-028 clr_busy SHALL be 1 exactly while state==CLEAR.
REQ-029 clr_req asserted during CLEAR SHALL be ignored, neither restarting nor extending the sweep.
REQ-030 The cursor SHALL remain unchanged during CLEAR until the home on exit.

Reset
REQ-031 rst SHALL override all other inputs, including mid-sweep and mid-transfer.
REQ-032 On reset: state IDLE, cursor_x=0, cursor_y=0, wr_en=0, wr_addr=0, wr_data=0, sweep counter=0, clr_busy=0.

Configuration
REQ-033 Macro CLEAR_ON_RESET_EN: when defined, reset SHALL put state in CLEAR with clr_busy=1, so a full sweep runs automatically after rst deasserts; all other reset values are per REQ-032.
REQ-034 Without CLEAR_ON_RESET_EN, reset SHALL enter IDLE and no sweep SHALL run until clr_req.

Verification
REQ-035 After reset, send "A" (0x41) -> next cycle wr_en=1, wr_addr=0, wr_data=0x41; then cursor_x=1, cursor_y=0.
REQ-036 Send 81 printable characters back-to-back with char_valid held -> 81 consecutive wr_en pulses at addresses 0..80; final cursor_x=1, cursor_y=1.
REQ-037 At cursor (5,59), send 0x0A -> no write; cursor becomes (0,0). Then 0x08 at x=0 -> cursor stays (0,0).
REQ-038 clr_req and char_valid asserted together in IDLE -> char_ready=0, character not accepted; 4800 writes of 0x20 at addresses 0..4799; clr_busy high 4800 cycles; cursor ends at (0,0).
REQ-039 Assert rst at sweep address 1000 -> next cycle wr_en=0, clr_busy=0, cursor (0,0); with CLEAR_ON_RESET_EN, a new sweep restarts from address 0 instead.
REQ-040 Pulse clr_req during a sweep -> the sweep still ends after exactly 4800 writes with no restart.

Source files
------------

// File: rtl/text_write_ctrl.sv
// Text-mode tile writer: turns a character stream into tile-memory writes with a
// cursor, and sweeps the screen with spaces on request. Macro CLEAR_ON_RESET_EN makes reset start a sweep.
module text_write_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
    localparam logic [7:0]        CH_BS     = 8'h08;
    localparam logic [7:0]        CH_LF     = 8'h0A;
    localparam logic [7:0]        CH_CR     = 8'h0D;
    localparam logic [7:0]        CH_SPACE  = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

`ifdef CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] sweep_cnt_r;
    logic [6:0]        cur_x_r;
    logic [6:0]        cur_x_s;
    logic [5:0]        cur_y_r;
    logic [5:0]        cur_y_s;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;
    logic              xfer_s;
    logic              sweep_done_s;
    logic              is_print_s;
    logic [ADDR_W-1:0] char_addr_s;

    function automatic logic [5:0] next_row(input logic [5:0] row);
        return (row == LAST_ROW) ? 6'd0 : row + 6'd1;
    endfunction

    assign char_ready   = (state_r == ST_IDLE) && !clr_req;
    assign xfer_s       = char_valid && char_ready;
    assign sweep_done_s = (state_r == ST_CLEAR) && (sweep_cnt_r == LAST_ADDR);
    assign is_print_s   = !(char_data inside {CH_BS, CH_LF, CH_CR});
    assign char_addr_s  = ADDR_W'(cur_y_r) * ADDR_W'(COLS) + ADDR_W'(cur_x_r);

    assign clr_busy = (state_r == ST_CLEAR);
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign cursor_x = cur_x_r;
    assign cursor_y = cur_y_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clear requests inside a sweep are deliberately ignored
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) state_s = ST_CLEAR;
                else         state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (sweep_done_s) state_s = ST_IDLE;
                else              state_s = ST_CLEAR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Cursor update: home at sweep end, otherwise driven by accepted characters
    always_comb begin
        cur_x_s = cur_x_r;
        cur_y_s = cur_y_r;
        if (sweep_done_s) begin
            cur_x_s = 7'd0;
            cur_y_s = 6'd0;
        end else if (xfer_s) begin
            case (char_data)
                CH_LF: begin
                    cur_x_s = 7'd0;
                    cur_y_s = next_row(cur_y_r);
                end
                CH_CR: cur_x_s = 7'd0;
                CH_BS: begin
                    if (cur_x_r != 7'd0) cur_x_s = cur_x_r - 7'd1;
                    else                 cur_x_s = cur_x_r;
                end
                default: begin
                    if (cur_x_r == LAST_COL) begin
                        cur_x_s = 7'd0;
                        cur_y_s = next_row(cur_y_r);
                    end else begin
                        cur_x_s = cur_x_r + 7'd1;
                    end
                end
            endcase
        end else begin
            cur_x_s = cur_x_r;
            cur_y_s = cur_y_r;
        end
    end

    // Write port, sweep counter and cursor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 8'h00;
            sweep_cnt_r <= '0;
            cur_x_r     <= 7'd0;
            cur_y_r     <= 6'd0;
        end else begin
            cur_x_r <= cur_x_s;
            cur_y_r <= cur_y_s;
            if (state_r == ST_CLEAR) begin
                wr_en_r     <= 1'b1;
                wr_addr_r   <= sweep_cnt_r;
                wr_data_r   <= CH_SPACE;
                sweep_cnt_r <= sweep_done_s ? '0 : sweep_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else if (xfer_s && is_print_s) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= char_addr_s;
                wr_data_r <= char_data;
            end else begin
                wr_en_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl (default build): directed table, corner sequences
// and random traffic checked against a cursor/sweep reference model.
module tb_text_write_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_clear;
    int m_idx, m_x, m_y, m_we, m_addr, m_data;

    text_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(13)) dut (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .clr_req(clr_req), .clr_busy(clr_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c);
        int pos;
        if (r) begin
            m_clear = 0; m_idx = 0; m_x = 0; m_y = 0; m_we = 0; m_addr = 0; m_data = 0;
        end else if (m_clear) begin
            m_we = 1; m_addr = m_idx; m_data = 8'h20;
            if (m_idx == CELLS - 1) begin
                m_clear = 0; m_idx = 0; m_x = 0; m_y = 0;
            end else begin
                m_idx++;
            end
        end else if (c) begin
            m_clear = 1; m_idx = 0; m_we = 0;
        end else if (v) begin
            m_we = 0;
            case (d)
                8'h0A: begin m_x = 0; m_y = (m_y + 1) % ROWS; end
                8'h0D: m_x = 0;
                8'h08: if (m_x > 0) m_x--;
                default: begin
                    m_we = 1; m_addr = m_y * COLS + m_x; m_data = d;
                    pos = (m_addr + 1) % CELLS;
                    m_x = pos % COLS; m_y = pos / COLS;
                end
            endcase
        end else begin
            m_we = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit c);
        rst = r; char_valid = v; char_data = d; clr_req = c;
        #1;
        chk("char_ready", int'(char_ready), int'(!m_clear && !c));
        model_step(r, v, d, c);
        @(posedge clk); #1;
        chk("wr_en", int'(wr_en), m_we);
        chk("wr_addr", int'(wr_addr), m_addr);
        chk("wr_data", int'(wr_data), m_data);
        chk("cursor_x", int'(cursor_x), m_x);
        chk("cursor_y", int'(cursor_y), m_y);
        chk("clr_busy", int'(clr_busy), int'(m_clear));
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        int          we, addr, data, x, y;
    } vec_t;

    vec_t tbl[8];
    int nwr, nbusy;

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1, 0,  8'h41, 1, 0};
        tbl[1] = '{1'b1, 8'h0D, 0, 0,  8'h41, 0, 0};
        tbl[2] = '{1'b1, 8'h42, 1, 0,  8'h42, 1, 0};
        tbl[3] = '{1'b1, 8'h08, 0, 0,  8'h42, 0, 0};
        tbl[4] = '{1'b1, 8'h08, 0, 0,  8'h42, 0, 0};
        tbl[5] = '{1'b1, 8'h0A, 0, 0,  8'h42, 0, 1};
        tbl[6] = '{1'b1, 8'h43, 1, 80, 8'h43, 1, 1};
        tbl[7] = '{1'b0, 8'h44, 0, 80, 8'h43, 1, 1};

        // reset state
        cycle(1, 1, 8'h41, 1);
        cycle(1, 0, 8'h00, 0);
        chk("reset_busy", int'(clr_busy), 0);
        chk("reset_wr_en", int'(wr_en), 0);

        for (int i = 0; i < 8; i++) begin
            cycle(0, tbl[i].v, tbl[i].d, 0);
            chk("tbl_wr_en", int'(wr_en), tbl[i].we);
            chk("tbl_wr_addr", int'(wr_addr), tbl[i].addr);
            chk("tbl_wr_data", int'(wr_data), tbl[i].data);
            chk("tbl_cursor_x", int'(cursor_x), tbl[i].x);
            chk("tbl_cursor_y", int'(cursor_y), tbl[i].y);
        end

        // 81 back-to-back printable characters wrap to the next row
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 81; i++) begin
            cycle(0, 1, 8'h30 + 8'(i % 10), 0);
            chk("b2b_wr_en", int'(wr_en), 1);
            chk("b2b_addr", int'(wr_addr), i);
        end
        chk("b2b_x", int'(cursor_x), 1);
        chk("b2b_y", int'(cursor_y), 1);

        // LF on the last row wraps to the top, BS at column 0 holds
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 59; i++) cycle(0, 1, 8'h0A, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'h78, 0);
        chk("pre_lf_x", int'(cursor_x), 5);
        chk("pre_lf_y", int'(cursor_y), 59);
        cycle(0, 1, 8'h0A, 0);
        chk("lf_wrap_we", int'(wr_en), 0);
        chk("lf_wrap_x", int'(cursor_x), 0);
        chk("lf_wrap_y", int'(cursor_y), 0);
        cycle(0, 1, 8'h08, 0);
        chk("bs_zero_x", int'(cursor_x), 0);
        chk("bs_zero_we", int'(wr_en), 0);

        // clear request beats a simultaneous character; full sweep then home
        cycle(0, 1, 8'h41, 0);
        cycle(0, 1, 8'h0A, 0);
        cycle(0, 1, 8'h41, 1);
        nbusy = int'(clr_busy);
        nwr = 0;
        for (int i = 0; i < 4805; i++) begin
            cycle(0, 0, 8'h00, 0);
            nbusy += int'(clr_busy);
            nwr += int'(wr_en);
        end
        chk("clr_writes", nwr, CELLS);
        chk("clr_busy_cycles", nbusy, CELLS);
        chk("clr_home_x", int'(cursor_x), 0);
        chk("clr_home_y", int'(cursor_y), 0);

        // clr_req pulsed mid-sweep neither restarts nor extends it
        cycle(0, 1, 8'h41, 0);
        cycle(0, 0, 8'h00, 1);
        nbusy = int'(clr_busy);
        nwr = 0;
        for (int i = 0; i < 4805; i++) begin
            cycle(0, 0, 8'h00, (i == 100 || i == 2000));
            nbusy += int'(clr_busy);
            nwr += int'(wr_en);
        end
        chk("pulse_writes", nwr, CELLS);
        chk("pulse_busy_cycles", nbusy, CELLS);

        // reset at sweep address 1000
        cycle(0, 1, 8'h41, 0);
        cycle(0, 0, 8'h00, 1);
        nwr = 0;
        for (int i = 0; i < 1200 && !(wr_en && wr_addr == 13'd1000); i++) begin
            cycle(0, 0, 8'h00, 0);
            nwr++;
        end
        chk("reach_addr_1000", int'(wr_addr), 1000);
        cycle(1, 0, 8'h00, 0);
        chk("rst_sweep_we", int'(wr_en), 0);
        chk("rst_sweep_busy", int'(clr_busy), 0);
        chk("rst_sweep_x", int'(cursor_x), 0);
        chk("rst_sweep_y", int'(cursor_y), 0);
        cycle(0, 0, 8'h00, 0);
        chk("rst_no_sweep", int'(clr_busy), 0);

        // random traffic against the model
        for (int i = 0; i < 12000; i++) begin
            int sel;
            logic [7:0] d;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: d = 8'h08;
                1: d = 8'h0A;
                2: d = 8'h0D;
                default: d = 8'($urandom);
            endcase
            cycle(($urandom_range(0, 2999) == 0), ($urandom_range(0, 3) != 0), d,
                  ($urandom_range(0, 3999) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
